// File: rtl/backprop_pkg.sv
// ---------------------------------------------------------------------------
// backprop_pkg
// Shared definitions for the backprop sequencer slice:
//   - state_t  : sequencer FSM states (IDLE, COST, UPDATE, DONE)
//   - index_t  : 32-bit unsigned layer/row index
//   - SIZE, LAYER_COUNT : default geometry (rows per layer, number of layers)
//   - is_beat_state() : true for states that present a beat to the consumer
// ---------------------------------------------------------------------------
package backprop_pkg;

    localparam int SIZE        = 3;
    localparam int LAYER_COUNT = 2;

    typedef logic [31:0] index_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COST   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic is_beat_state(input state_t s);
        return (s == ST_COST) || (s == ST_UPDATE);
    endfunction

endpackage

// File: rtl/backprop_sequencer_if.sv
// ---------------------------------------------------------------------------
// backprop_sequencer_if
// Handshake/beat bundle between a requester (master) and the sequencer (slave).
//   start          : master -> slave, request one full pass
//   advance        : master -> slave, consumer ready / retire current beat
//   busy, done     : slave -> master, pass status
//   is_update, backprop_cost, is_cost_layer,
//   w_layer_index, w_row_index : slave -> master, current beat
// ---------------------------------------------------------------------------
interface backprop_sequencer_if;
    import backprop_pkg::*;

    logic   start;
    logic   advance;
    logic   busy;
    logic   done;
    logic   is_update;
    logic   backprop_cost;
    logic   is_cost_layer;
    index_t w_layer_index;
    index_t w_row_index;

    modport master (
        output start, advance,
        input  busy, done, is_update, backprop_cost, is_cost_layer,
               w_layer_index, w_row_index
    );

    modport slave (
        input  start, advance,
        output busy, done, is_update, backprop_cost, is_cost_layer,
               w_layer_index, w_row_index
    );

endinterface

// File: rtl/backprop_index_counter.sv
// ---------------------------------------------------------------------------
// backprop_index_counter
// Row/layer counter pair walked by the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force both indices to 0 (highest priority)
//   load       : start a pass: layer = layer_count-1, row = 0
//   step       : retire one beat: row increments; at row size-1 the row
//                wraps to 0 and the layer decrements
//   row, layer : current indices
//   last_row   : row == size-1
//   last_beat  : last row of layer 0 (final beat of a pass)
// ---------------------------------------------------------------------------
module backprop_index_counter
    import backprop_pkg::*;
#(
    parameter int size        = SIZE,
    parameter int layer_count = LAYER_COUNT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  logic   load,
    input  logic   step,
    output index_t row,
    output index_t layer,
    output logic   last_row,
    output logic   last_beat
);

    localparam index_t ROW_LAST  = index_t'(size - 1);
    localparam index_t LAYER_TOP = index_t'(layer_count - 1);

    index_t row_reg;
    index_t layer_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg   <= '0;
            layer_reg <= '0;
        end else if (clear) begin
            row_reg   <= '0;
            layer_reg <= '0;
        end else if (load) begin
            row_reg   <= '0;
            layer_reg <= LAYER_TOP;
        end else if (step) begin
            if (row_reg == ROW_LAST) begin
                row_reg <= '0;
                // The sequencer leaves UPDATE before layer 0 wraps; the guard
                // keeps the index from ever underflowing regardless.
                if (layer_reg != '0) begin
                    layer_reg <= layer_reg - index_t'(1);
                end
            end else begin
                row_reg <= row_reg + index_t'(1);
            end
        end
    end

    assign row       = row_reg;
    assign layer     = layer_reg;
    assign last_row  = (row_reg == ROW_LAST);
    assign last_beat = (row_reg == ROW_LAST) && (layer_reg == '0);

endmodule

// File: rtl/backprop_sequencer.sv
// ---------------------------------------------------------------------------
// backprop_sequencer
// Walks one backprop pass per start request: size beats of the cost layer
// (layer_count-1), then size beats of every lower layer down to layer 0,
// then a single-cycle done pulse. Each beat is held until advance=1.
//   clk   : clock
//   rst_n : asynchronous active-low reset; abandons any pass in flight
//   bus   : backprop_sequencer_if.slave (start/advance in, beat/status out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module backprop_sequencer
    import backprop_pkg::*;
#(
    parameter int size        = SIZE,
    parameter int layer_count = LAYER_COUNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    backprop_sequencer_if.slave  bus
);

    state_t state_reg;
    state_t state_next;

    logic   busy_reg;
    logic   done_reg;
    logic   is_update_reg;
    logic   cost_phase_reg;

    logic   cnt_clear;
    logic   cnt_load;
    logic   cnt_step;
    index_t row_index;
    index_t layer_index;
    logic   last_row;
    logic   last_beat;

    backprop_index_counter #(
        .size        (size),
        .layer_count (layer_count)
    ) u_index_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .step      (cnt_step),
        .row       (row_index),
        .layer     (layer_index),
        .last_row  (last_row),
        .last_beat (last_beat)
    );

    always_comb begin
        state_next = state_reg;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_COST;
                    cnt_load   = 1'b1;
                end
            end
            ST_COST: begin
                if (bus.advance) begin
                    if (last_row && (layer_count == 1)) begin
                        state_next = ST_DONE;
                        cnt_clear  = 1'b1;
                    end else begin
                        // Wrapping out of the cost layer lands on layer_count-2.
                        if (last_row) begin
                            state_next = ST_UPDATE;
                        end
                        cnt_step = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                if (bus.advance) begin
                    if (last_beat) begin
                        state_next = ST_DONE;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here: no queued pass.
                state_next = ST_IDLE;
                cnt_clear  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with the
    // counter values loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            is_update_reg  <= 1'b0;
            cost_phase_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE);
            is_update_reg  <= is_beat_state(state_next);
            cost_phase_reg <= (state_next == ST_COST);
        end
    end

    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.is_update     = is_update_reg;
    // Cost-phase beats are exactly the beats that address the cost layer.
    assign bus.backprop_cost = cost_phase_reg;
    assign bus.is_cost_layer = cost_phase_reg;
    assign bus.w_layer_index = layer_index;
    assign bus.w_row_index   = row_index;

endmodule

// File: doc/backprop_sequencer.md
BACKPROP_SEQUENCER -- requirements
Module: backprop_sequencer

Interface
REQ-001 Parameter size, default 3: rows per layer; row index wraps at size-1.
REQ-002 Parameter layer_count, default 2: number of layers; layer layer_count-1 is the cost layer.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request one full backprop pass; sampled only in IDLE.
REQ-006 advance  input  1  consumer ready; current beat is retired on a clock edge where advance=1.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse after the last beat of a pass is retired.
REQ-009 is_update  output  1  a valid beat is presented on the outputs below.
REQ-010 backprop_cost  output  1  beat belongs to the cost phase.
REQ-011 is_cost_layer  output  1  beat addresses the cost layer.
REQ-012 w_layer_index  output  32  layer of the current beat.
REQ-013 w_row_index  output  32  row of the current beat.

Function
REQ-014 FSM states SHALL be IDLE, COST, UPDATE, DONE; all outputs registered.
REQ-015 IDLE: is_update, backprop_cost, is_cost_layer, busy, done and both indices SHALL be 0.
REQ-016 IDLE with start=1 SHALL enter COST with layer=layer_count-1, row=0; first beat is visible the cycle after start is sampled.
REQ-017 COST beats: is_update=1, backprop_cost=1, is_cost_layer=1, layer=layer_count-1, rows 0..size-1 in order.
REQ-018 A beat SHALL hold all outputs stable while advance=0; no beat is skipped or repeated.
REQ-019 Retiring row size-1 in COST: layer_count>1 SHALL go to UPDATE with layer=layer_count-2, row=0; layer_count=1 SHALL go to DONE.
REQ-020 UPDATE beats: is_update=1, backprop_cost=0, is_cost_layer=0; row increments 0..size-1 per retired beat.
REQ-021 Retiring row size-1 in UPDATE: row wraps to 0 and layer decrements; retiring row size-1 of layer 0 SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, is_update=0, busy=1, indices 0; it then returns to IDLE unconditionally.
REQ-023 start outside IDLE SHALL be ignored. start=1 in the DONE cycle is not queued.
REQ-024 size=1: each layer is one beat. Row 0 is both first and last.
REQ-025 Index counters SHALL be 32-bit unsigned. Layer decrement below 0 SHALL never occur; the FSM leaves UPDATE first.
REQ-026 Total beats per pass SHALL be size*layer_count.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and all outputs to 0, regardless of clk.
REQ-028 Reset mid-pass SHALL abandon the pass with no done pulse.
REQ-029 After rst_n rises, the block SHALL wait in IDLE for a new start.

Structure
REQ-030 A shared package backprop_pkg SHALL hold the state enum, default SIZE/LAYER_COUNT constants and the 32-bit index typedef.
REQ-031 One sub-module backprop_index_counter SHALL implement the row/layer counter pair: row wrap, layer decrement, last-beat flag.
REQ-032 Outputs SHALL directly drive backprop_stack_controller's is_update, backprop_cost, is_cost_layer, w_layer_index and w_row_index inputs.

Verification
REQ-033 size=3, layer_count=3, advance=1 constantly, start pulse -> 9 consecutive beats; rows 0,1,2 per layer; layers 2(cost),1,0; done on cycle 10 after start.
REQ-034 Same config, advance=0 for 4 cycles on layer 1 row 1 -> outputs frozen at (1,1) for those cycles; pass then completes with 9 beats total.
REQ-035 layer_count=1, size=3 -> 3 COST beats, then done, with no UPDATE beat.
REQ-036 rst_n pulsed low on layer 1 row 2 -> outputs 0 asynchronously, busy=0, no done; a following start runs a full 9-beat pass.
REQ-037 start held high through a pass -> start is ignored while busy; a new pass begins only after DONE returns to IDLE, first beat 2 cycles after done.
REQ-038 size=1, layer_count=2 -> beats (layer 1, row 0, cost) then (layer 0, row 0), then done.
